riscv_icache_fill_fsm: RTL
==========================

// Module: riscv_icache_fill_fsm
// PURPOSE
//  Next-generation instruction-cache control FSM between the icache tag/data memories and the BIU.
//  Fills whole lines as wrapping critical-word-first bursts of BEATS beats.
//  Forwards the critical beat to the fetch stage before the fill completes.
//  Services non-cacheable fetches and whole-cache invalidation.
//  Optionally prefetches the next sequential line.
// PARAMETERS
//  XLEN        32   data/beat width (32|64)
//  PLEN        34   physical address width
//  BLOCK_SIZE  32   line size in bytes; power of 2, >= XLEN/8
//  WAYS        2    associativity (fill_way one-hot width)
//  BEATS       BLOCK_SIZE*8/XLEN   beats per line fill (derived, >=1)
// PORTS
//  clk_i           in   1          clock
//  rst_i           in   1          asynchronous active-high reset
//  req_i           in   1          fetch request
//  adr_i           in   PLEN       fetch physical address
//  cacheable_i     in   1          address is cacheable
//  flush_i         in   1          pipe flush; kills req_i this cycle
//  invalidate_i    in   1          invalidate entire icache (1-cycle pulse)
//  dc_clean_rdy_i  in   1          dcache clean complete
//  cache_hit_i     in   1          tag hit for adr_i (or pf_adr_o when pf_lookup_o=1)
//  cache_q_i       in   XLEN       hit data word for adr_i
//  fill_way_i      in   WAYS       victim way (one-hot)
//  stall_o         out  1          stall fetch stage
//  armed_o         out  1          FSM idle, lookups valid
//  inv_all_o       out  1          clear all valid bits
//  fill_way_o      out  WAYS       way being filled
//  line_we_o       out  1          write biu_q_i into beat line_beat_o of line_adr_o
//  line_beat_o     out  log2(BEATS) beat index within line
//  line_adr_o      out  PLEN       line-aligned fill address
//  line_valid_o    out  1          1-cycle pulse: set valid/tag of filled line
//  biu_req_o       out  1          BIU command request
//  biu_ack_i       in   1          BIU command accepted
//  biu_adr_o       out  PLEN       command address
//  biu_len_o       out  8          burst length-1
//  biu_nc_o        out  1          command is non-cacheable single beat
//  biu_d_ack_i     in   1          read data beat valid
//  biu_q_i         in   XLEN       read data
//  biu_err_i       in   1          bus error with this beat
//  pf_lookup_o     out  1          tag lookup is for pf_adr_o (prefetch only)
//  pf_adr_o        out  PLEN       next-line address (prefetch only)
//  parcel_o        out  XLEN       fetched word
//  parcel_valid_o  out  1          parcel_o valid
//  parcel_error_o  out  1          parcel carries bus error
// BEHAVIOUR
//  Reset: state=ARMED, armed_o=1; all other outputs 0; fill_way_o=0; beat counter=0; inv_hold=0.
//  valid_req = req_i & ~flush_i.
//  inv_hold latches invalidate_i; clears when inv_all_o asserts.
//  ARMED, priority order:
//   1. invalidate_i|inv_hold -> INVALIDATE, inv_all_o=1.
//   2. valid_req & ~cacheable_i -> NC_REQ.
//   3. valid_req & cacheable_i & ~cache_hit_i -> FILL_REQ; latch line addr, crit beat=adr_i beat field, fill_way_i.
//   4. Hit: parcel_o=cache_q_i, parcel_valid_o=1 same cycle, stall_o=0.
//  INVALIDATE: stall; on dc_clean_rdy_i -> RECOVER0, inv_all_o=0.
//  NC_REQ: biu_req_o=1, biu_nc_o=1, biu_len_o=0, biu_adr_o=adr_i XLEN-aligned; on biu_ack_i -> NC_WAIT.
//  NC_WAIT: on biu_d_ack_i -> parcel_valid_o=~flush seen, parcel_error_o=biu_err_i -> ARMED.
//   A flush while in NC_REQ/NC_WAIT still completes the transfer; its parcel is suppressed.
//  FILL_REQ: biu_req_o=1, biu_len_o=BEATS-1, biu_adr_o=line addr|crit beat offset (wrapping burst); on biu_ack_i -> FILL_DATA.
//  FILL_DATA: each biu_d_ack_i -> line_we_o=1, line_beat_o=counter; counter increments mod BEATS (wraps to 0).
//   First beat (crit) -> parcel_valid_o=1 if the request is unflushed and adr_i is still in the line at that beat.
//   Later beats are also forwarded when adr_i matches the line and line_beat_o, else stall_o=1.
//   After BEATS beats -> RECOVER0; line_valid_o pulses unless any beat had biu_err_i.
//   Any erroneous beat: write suppressed, parcel_error_o=1 if forwarded; the burst is always drained.
//  RECOVER0 -> RECOVER1 -> ARMED (stall_o=1, two-cycle tag/data re-read).
//   armed_o=1 only in ARMED.
//  stall_o: ARMED: inv pending | (valid_req & (cacheable ? ~hit : 1)); 1 in all other states unless forwarding.
//  Flush mid-fill: fill completes and the line is validated; no parcel is delivered for the killed request.
//  invalidate_i mid-fill: held; serviced on the first ARMED cycle after RECOVER1.
//  BEATS==1: crit beat=0; the fill is a single beat.
// CONFIGURATION
//  ICACHE_NEXTLINE_PREFETCH_EN defined:
//   - After RECOVER1 with no inv pending, enter PF_LOOKUP: pf_lookup_o=1, pf_adr_o=line_adr+BLOCK_SIZE (wraps at 2^PLEN).
//   - On cache_hit_i=0 -> PF_FILL: same as FILL_REQ/FILL_DATA with crit beat 0, fill_way_i resampled; no parcel forwarding.
//   - During PF_FILL, a hit on adr_i is served with stall_o=0; a miss stalls until the prefetch drains, then is handled.
//   - Prefetch never crosses a non-cacheable request.
//  Undefined: PF states absent; pf_lookup_o=0 and pf_adr_o=0 tied.
// TESTING
//  Hit: req adr=0x100 cacheable, hit=1 -> parcel_valid_o same cycle, stall_o=0, no biu_req_o.
//  CWF miss: BLOCK_SIZE=32, XLEN=32, adr=0x10C -> biu_adr_o=0x10C, len=7; beats 3,4..7,0..2.
//   parcel_valid_o on beat 3; line_valid_o after the 8th beat.
//  Error: miss; biu_err_i on beat 5 -> all 8 beats drained, line_valid_o never pulses, ARMED after RECOVER1.
//  Invalidate mid-fill: invalidate_i at beat 2 -> fill completes.
//   ARMED one cycle -> INVALIDATE; exits only after dc_clean_rdy_i.
//  NC with flush: adr=0x203 non-cacheable -> biu_adr_o=0x200, biu_nc_o=1.
//   flush_i in NC_WAIT -> no parcel_valid_o, ARMED after biu_d_ack_i.
//  Prefetch (macro on): miss 0x100 -> pf_adr_o=0x120; pf hit=0 -> second burst at 0x120, beats 0..7.
//   A hit request during it -> stall_o=0.

Source files
------------

// File: rtl/riscv_icache_fill_fsm.sv
// Instruction-cache fill controller: critical-word-first line fills, non-cacheable fetches, full invalidation.
// Define ICACHE_NEXTLINE_PREFETCH_EN to build the next-line prefetcher (PF_LOOKUP/PF_REQ/PF_DATA states).
module riscv_icache_fill_fsm #(
    parameter  int XLEN       = 32,
    parameter  int PLEN       = 34,
    parameter  int BLOCK_SIZE = 32,
    parameter  int WAYS       = 2,
    localparam int BEATS      = BLOCK_SIZE * 8 / XLEN,
    localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [PLEN-1:0] adr_i,
    input  logic            cacheable_i,
    input  logic            flush_i,
    input  logic            invalidate_i,
    input  logic            dc_clean_rdy_i,
    input  logic            cache_hit_i,
    input  logic [XLEN-1:0] cache_q_i,
    input  logic [WAYS-1:0] fill_way_i,
    output logic            stall_o,
    output logic            armed_o,
    output logic            inv_all_o,
    output logic [WAYS-1:0] fill_way_o,
    output logic            line_we_o,
    output logic [BW-1:0]   line_beat_o,
    output logic [PLEN-1:0] line_adr_o,
    output logic            line_valid_o,
    output logic            biu_req_o,
    input  logic            biu_ack_i,
    output logic [PLEN-1:0] biu_adr_o,
    output logic [7:0]      biu_len_o,
    output logic            biu_nc_o,
    input  logic            biu_d_ack_i,
    input  logic [XLEN-1:0] biu_q_i,
    input  logic            biu_err_i,
    output logic            pf_lookup_o,
    output logic [PLEN-1:0] pf_adr_o,
    output logic [XLEN-1:0] parcel_o,
    output logic            parcel_valid_o,
    output logic            parcel_error_o
);

    localparam int              OFF       = $clog2(XLEN / 8);
    localparam int              LOFF      = $clog2(BLOCK_SIZE);
    localparam logic [PLEN-1:0] LINE_MASK = ~PLEN'(BLOCK_SIZE - 1);
    localparam logic [PLEN-1:0] WORD_MASK = ~PLEN'(XLEN / 8 - 1);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [3:0] {
        ARMED, INVALIDATE, NC_REQ, NC_WAIT, FILL_REQ, FILL_DATA, RECOVER0, RECOVER1
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
        , PF_LOOKUP, PF_REQ, PF_DATA
`endif
    } state_t;

    state_t          state_q, state_d;
    logic            inv_hold_q, inv_hold_d;
    logic            inv_all_q, inv_all_d;
    logic [WAYS-1:0] fill_way_q, fill_way_d;
    logic [PLEN-1:0] line_adr_q, line_adr_d;
    logic [BW-1:0]   crit_q, crit_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BW-1:0]   rcv_cnt_q, rcv_cnt_d;
    logic            err_q, err_d;
    logic            flushed_q, flushed_d;
    logic [PLEN-1:0] nc_adr_q, nc_adr_d;
    logic            line_valid_q, line_valid_d;

    logic            valid_req, inv_pend, hit_req, in_line, fwd, nc_deliver, data_phase;
    logic [BW-1:0]   adr_beat;
    logic [PLEN-1:0] fill_adr;

    assign valid_req  = req_i & ~flush_i;
    assign inv_pend   = invalidate_i | inv_hold_q;
    assign hit_req    = valid_req & cacheable_i & cache_hit_i;
    assign adr_beat   = (BEATS > 1) ? adr_i[OFF +: BW] : '0;
    assign in_line    = (adr_i[PLEN-1:LOFF] == line_adr_q[PLEN-1:LOFF]);
    assign fwd        = biu_d_ack_i & valid_req & ~flushed_q & in_line & (adr_beat == beat_cnt_q);
    assign nc_deliver = ~(flushed_q | flush_i);
    assign fill_adr   = line_adr_q | (PLEN'(crit_q) << OFF);

    assign armed_o      = (state_q == ARMED);
    assign inv_all_o    = inv_all_q;
    assign fill_way_o   = fill_way_q;
    assign line_adr_o   = line_adr_q;
    assign line_beat_o  = beat_cnt_q;
    assign line_valid_o = line_valid_q;

`ifdef ICACHE_NEXTLINE_PREFETCH_EN
    logic            pf_ok_q, pf_ok_d;
    logic [PLEN-1:0] pf_adr;

    assign pf_adr      = line_adr_q + PLEN'(BLOCK_SIZE);
    assign pf_adr_o    = pf_adr;
    assign pf_lookup_o = (state_q == PF_LOOKUP);
    assign data_phase  = (state_q == FILL_DATA) | (state_q == PF_DATA);
`else
    assign pf_adr_o    = '0;
    assign pf_lookup_o = 1'b0;
    assign data_phase  = (state_q == FILL_DATA);
`endif

    always_comb begin
        state_d        = state_q;
        inv_hold_d     = inv_all_q ? 1'b0 : (inv_hold_q | invalidate_i);
        inv_all_d      = inv_all_q;
        fill_way_d     = fill_way_q;
        line_adr_d     = line_adr_q;
        crit_d         = crit_q;
        beat_cnt_d     = beat_cnt_q;
        rcv_cnt_d      = rcv_cnt_q;
        err_d          = err_q;
        flushed_d      = flushed_q | flush_i;
        nc_adr_d       = nc_adr_q;
        line_valid_d   = 1'b0;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
        pf_ok_d        = pf_ok_q;
`endif
        stall_o        = 1'b1;
        parcel_o       = biu_q_i;
        parcel_valid_o = 1'b0;
        parcel_error_o = 1'b0;
        line_we_o      = 1'b0;
        biu_req_o      = 1'b0;
        biu_adr_o      = '0;
        biu_len_o      = '0;
        biu_nc_o       = 1'b0;

        // Beat bookkeeping shared by demand and prefetch bursts; erroneous beats are drained, not written.
        if (data_phase && biu_d_ack_i) begin
            line_we_o  = ~biu_err_i;
            beat_cnt_d = (BEATS > 1) ? beat_cnt_q + 1'b1 : '0;
            rcv_cnt_d  = rcv_cnt_q + 1'b1;
            err_d      = err_q | biu_err_i;
            if (rcv_cnt_q == LAST_BEAT) begin
                state_d      = RECOVER0;
                line_valid_d = ~(err_q | biu_err_i);
            end
        end

        case (state_q)
            ARMED: begin
                stall_o  = inv_pend | (valid_req & ~(cacheable_i & cache_hit_i));
                parcel_o = cache_q_i;
                if (inv_pend) begin
                    state_d   = INVALIDATE;
                    inv_all_d = 1'b1;
                end else if (valid_req && !cacheable_i) begin
                    state_d   = NC_REQ;
                    nc_adr_d  = adr_i & WORD_MASK;
                    flushed_d = 1'b0;
                end else if (valid_req && !cache_hit_i) begin
                    state_d    = FILL_REQ;
                    line_adr_d = adr_i & LINE_MASK;
                    crit_d     = adr_beat;
                    beat_cnt_d = adr_beat;
                    rcv_cnt_d  = '0;
                    err_d      = 1'b0;
                    fill_way_d = fill_way_i;
                    flushed_d  = 1'b0;
                end else begin
                    parcel_valid_o = hit_req;
                end
            end
            INVALIDATE: begin
                if (dc_clean_rdy_i) begin
                    state_d   = RECOVER0;
                    inv_all_d = 1'b0;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
                    pf_ok_d   = 1'b0;
`endif
                end
            end
            NC_REQ: begin
                biu_req_o = 1'b1;
                biu_nc_o  = 1'b1;
                biu_adr_o = nc_adr_q;
                if (biu_ack_i) state_d = NC_WAIT;
            end
            NC_WAIT: begin
                if (biu_d_ack_i) begin
                    parcel_valid_o = nc_deliver;
                    parcel_error_o = nc_deliver & biu_err_i;
                    stall_o        = ~nc_deliver;
                    state_d        = ARMED;
                end
            end
            FILL_REQ: begin
                biu_req_o = 1'b1;
                biu_len_o = 8'(BEATS - 1);
                biu_adr_o = fill_adr;
                if (biu_ack_i) state_d = FILL_DATA;
            end
            FILL_DATA: begin
                parcel_valid_o = fwd;
                parcel_error_o = fwd & biu_err_i;
                stall_o        = ~fwd;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
                if (biu_d_ack_i && rcv_cnt_q == LAST_BEAT) pf_ok_d = ~(err_q | biu_err_i);
`endif
            end
            RECOVER0: state_d = RECOVER1;
            RECOVER1: begin
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
                state_d = (pf_ok_q && !inv_pend) ? PF_LOOKUP : ARMED;
                pf_ok_d = 1'b0;
`else
                state_d = ARMED;
`endif
            end
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
            PF_LOOKUP: begin
                if (inv_pend || (valid_req && !cacheable_i) || cache_hit_i) begin
                    state_d = ARMED;
                end else begin
                    state_d    = PF_REQ;
                    line_adr_d = pf_adr;
                    crit_d     = '0;
                    beat_cnt_d = '0;
                    rcv_cnt_d  = '0;
                    err_d      = 1'b0;
                    fill_way_d = fill_way_i;
                end
            end
            PF_REQ: begin
                stall_o        = ~hit_req;
                parcel_valid_o = hit_req;
                parcel_o       = cache_q_i;
                biu_req_o      = 1'b1;
                biu_len_o      = 8'(BEATS - 1);
                biu_adr_o      = fill_adr;
                if (biu_ack_i) state_d = PF_DATA;
            end
            PF_DATA: begin
                stall_o        = ~hit_req;
                parcel_valid_o = hit_req;
                parcel_o       = cache_q_i;
            end
`endif
            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ARMED;
            inv_hold_q   <= 1'b0;
            inv_all_q    <= 1'b0;
            fill_way_q   <= '0;
            line_adr_q   <= '0;
            crit_q       <= '0;
            beat_cnt_q   <= '0;
            rcv_cnt_q    <= '0;
            err_q        <= 1'b0;
            flushed_q    <= 1'b0;
            nc_adr_q     <= '0;
            line_valid_q <= 1'b0;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
            pf_ok_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            inv_hold_q   <= inv_hold_d;
            inv_all_q    <= inv_all_d;
            fill_way_q   <= fill_way_d;
            line_adr_q   <= line_adr_d;
            crit_q       <= crit_d;
            beat_cnt_q   <= beat_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            err_q        <= err_d;
            flushed_q    <= flushed_d;
            nc_adr_q     <= nc_adr_d;
            line_valid_q <= line_valid_d;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
            pf_ok_q      <= pf_ok_d;
`endif
        end
    end

endmodule
